// File: rtl/shift_left_unit_seq_pkg.sv
// Shared definitions for the multi-cycle left-shift unit: mode codes, FSM
// encodings and the per-bit 4:1 selector used by the one-step shifter.
package shift_left_unit_seq_pkg;

    typedef enum logic [1:0] {
        SHL_LOG = 2'b00,
        SHL_ROT = 2'b01,
        SHL_CRY = 2'b10,
        SHL_REP = 2'b11
    } shl_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shl_state_e;

    function automatic logic mux4to1(input logic [3:0] d, input logic [1:0] s);
        logic y;
        case (s)
            2'b00:   y = d[0];
            2'b01:   y = d[1];
            2'b10:   y = d[2];
            2'b11:   y = d[3];
            default: y = 1'b0;
        endcase
        return y;
    endfunction

endpackage

// File: rtl/shift_left_unit_seq_step.sv
// Combinational single-step left shifter: every result bit is picked by a
// 4:1 selector; only bit 0 differs between the modes.
module shl_step_8bit
    import shift_left_unit_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] f,
    input  logic             cout,
    input  shl_mode_e        mode,
    output logic [WIDTH-1:0] f_nxt,
    output logic             cout_nxt
);

    // Next-value selection for one 1-bit left step
    always_comb begin
        f_nxt    = {WIDTH{1'b0}};
        cout_nxt = f[WIDTH-1];
        // bit 0 inputs ordered by mode code: REP, CRY, ROT, LOG
        f_nxt[0] = mux4to1({f[0], cout, f[WIDTH-1], 1'b0}, mode);
        for (int i = 1; i < WIDTH; i++) begin
            f_nxt[i] = mux4to1({4{f[i-1]}}, mode);
        end
    end

endmodule

// File: rtl/shift_left_unit_seq.sv
// Multi-cycle left-shift unit: FSM, step counter and result registers; the
// actual bit movement is done by shl_step_8bit one position per clock.
module shift_left_unit_seq
    import shift_left_unit_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sel0,
    input  logic             sel1,
    input  logic [WIDTH-1:0] x,
    input  logic             cin,
    input  logic [CNT_W-1:0] amount,
    output logic [WIDTH-1:0] f,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    shl_state_e       state_r;
    shl_mode_e        mode_r;
    logic [WIDTH-1:0] f_r;
    logic             cout_r;
    logic [CNT_W-1:0] count_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] f_nxt_s;
    logic             cout_nxt_s;
    shl_mode_e        mode_in_s;

    assign mode_in_s = shl_mode_e'({sel1, sel1 ? sel0 : sel0});

    shl_step_8bit #(.WIDTH(WIDTH)) u_step (
        .f        (f_r),
        .cout     (cout_r),
        .mode     (mode_r),
        .f_nxt    (f_nxt_s),
        .cout_nxt (cout_nxt_s)
    );

    // Control FSM with registered result, counter and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= SHL_LOG;
            f_r     <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        f_r     <= x;
                        // only the through-carry mode seeds the carry from cin
                        cout_r  <= (mode_in_s == SHL_CRY) ? cin : 1'b0;
                        count_r <= amount;
                        mode_r  <= mode_in_s;
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (count_r != {CNT_W{1'b0}}) begin
                        f_r     <= f_nxt_s;
                        cout_r  <= cout_nxt_s;
                        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign f    = f_r;
    assign cout = cout_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_shift_left_unit_seq.sv
// Scoreboard bench for shift_left_unit_seq: stimulus pushes arithmetic-model
// expectations, an independent monitor checks every done pulse.
module tb_shift_left_unit_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sel0, sel1;
    logic [7:0] x;
    logic       cin;
    logic [2:0] amount;
    logic [7:0] f;
    logic       cout;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] f;
        logic       cout;
        int         amt;
        int         accept_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    logic prev_done = 1'b0;
    logic [8:0] last_exp;

    shift_left_unit_seq #(.WIDTH(8), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sel0(sel0), .sel1(sel1),
        .x(x), .cin(cin), .amount(amount), .f(f), .cout(cout),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: whole-operation result from plain integer arithmetic, {cout,f}
    function automatic logic [8:0] model(input int mode, input logic [7:0] xv,
                                         input logic c, input int n);
        int xi, fo, co, v;
        xi = int'(xv);
        fo = 0; co = 0;
        case (mode)
            0: begin fo = (xi << n) & 255;                       co = (n == 0) ? 0 : (xi >> (8 - n)) & 1; end
            1: begin fo = ((xi << n) | (xi >> (8 - n))) & 255;   co = (n == 0) ? 0 : (xi >> (8 - n)) & 1; end
            2: begin
                v  = (int'(c) << 8) | xi;
                v  = ((v << n) | (v >> (9 - n))) & 511;
                fo = v & 255;
                co = (v >> 8) & 1;
            end
            default: begin
                fo = ((xi << n) | (((xi & 1) != 0) ? ((1 << n) - 1) : 0)) & 255;
                co = (n == 0) ? 0 : (xi >> (8 - n)) & 1;
            end
        endcase
        return {co[0], fo[7:0]};
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            if (prev_done) check("done_single_pulse", 1, 0);
            check("busy_at_done", int'(busy), 1);
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("result_f", int'(f), int'(e.f));
                check("result_cout", int'(cout), int'(e.cout));
                check("latency", cyc - e.accept_cyc, e.amt + 1);
            end
        end
        prev_done <= done;
    end

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge clk);
        while ((busy || sb.size() != 0) && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (k >= 40) check("idle_timeout", 1, 0);
    endtask

    // Issue one operation at a negedge in IDLE; inputs are scrambled afterwards
    task automatic issue(input int mode, input logic [7:0] xv, input logic c, input int n);
        exp_t e;
        logic [8:0] m;
        m = model(mode, xv, c, n);
        {sel1, sel0} = mode[1:0];
        x = xv; cin = c; amount = n[2:0]; start = 1'b1;
        e.f = m[7:0]; e.cout = m[8]; e.amt = n; e.accept_cyc = cyc + 1;
        sb.push_back(e);
        last_exp = m;
        @(posedge clk);
        #1;
        start = 1'b0;
        x = 8'($urandom); cin = 1'($urandom); amount = 3'($urandom);
        {sel1, sel0} = 2'($urandom);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b1; sel0 = 1'b0; sel1 = 1'b0;
        x = 8'hA5; cin = 1'b1; amount = 3'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_outputs", int'({f, cout, busy, done}), 0);
        end
        start = 1'b0;
        rst_n = 1'b1;

        wait_idle(); issue(0, 8'b1000_0001, 1'b0, 1); wait_idle();
        check("dir_mode00", int'({cout, f}), int'({1'b1, 8'b0000_0010}));
        issue(1, 8'b1001_0110, 1'b0, 3); wait_idle();
        check("dir_mode01", int'({cout, f}), int'({1'b0, 8'b1011_0100}));
        issue(2, 8'b1100_0000, 1'b1, 2); wait_idle();
        check("dir_mode10", int'({cout, f}), int'({1'b1, 8'b0000_0011}));
        issue(3, 8'b0000_0101, 1'b0, 4); wait_idle();
        check("dir_mode11", int'({cout, f}), int'({1'b0, 8'b0101_1111}));

        // amount 0 in every mode, then confirm results hold while idle
        for (int md = 0; md < 4; md++) begin
            issue(md, 8'h9C, 1'b1, 0); wait_idle();
        end
        repeat (3) @(negedge clk);
        check("hold_after_done", int'({cout, f}), int'(last_exp));

        // start pulsed during SHIFT must be ignored
        issue(1, 8'h3C, 1'b0, 6);
        @(negedge clk); @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        check("no_queued_start", int'(busy), 0);

        // reset mid-SHIFT aborts with no done
        issue(0, 8'hFF, 1'b0, 7);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midshift_reset", int'({f, cout, busy, done}), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_idle", int'({busy, done}), 0);

        // randomized operations
        for (int i = 0; i < 60; i++) begin
            issue(int'($urandom_range(0, 3)), 8'($urandom), 1'($urandom),
                  int'($urandom_range(0, 7)));
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
